// File: rtl/rv32i_pkg.sv
// Shared RV32I decode encodings: opcodes, ALU operation codes, ALU B-operand
// select values and the bundle of registered control bits.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_LUI  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } alu_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } srcb_e;

  typedef struct packed {
    alu_e  alu_code;
    logic  alu_src_a;
    srcb_e alu_src_b;
    logic  mem_read;
    logic  mem_write;
    logic  mem_to_reg;
    logic  reg_write;
    logic  jump;
    logic  jalr;
    logic  sb_type;
  } ctrl_t;

  // funct3 to ALU operation; alt selects SUB/SRA (Instruction[30])
  function automatic alu_e alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// Combinational RV32I immediate generator: I/S/B/U/J formats, sign-extended.
// Only Instruction[31:7] carries immediate bits, so the opcode is not an input.
module rv32i_imm_gen (
  input  logic [31:7] instr_i,
  output logic [31:0] imm_i_o,
  output logic [31:0] imm_s_o,
  output logic [31:0] imm_b_o,
  output logic [31:0] imm_u_o,
  output logic [31:0] imm_j_o
);

  assign imm_i_o = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                    instr_i[11:8], 1'b0};
  assign imm_u_o = {instr_i[31:12], 12'b0};
  assign imm_j_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

endmodule

// File: rtl/rv32i_decode.sv
// RV32I ID-stage decoder with registered outputs (ID/EX boundary, latency 1).
// Optional macro RV32I_DECODE_ILLEGAL_EN adds a registered `illegal` flag and
// zeroes every other output when an encoding is flagged illegal.
module rv32i_decode
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction,
  output logic [4:0]  rs1Addr,
  output logic [4:0]  rs2Addr,
  output logic [4:0]  rdAddr,
  output logic [2:0]  funct3,
  output logic [31:0] Imm,
  output logic [31:0] offset,
  output logic [3:0]  ALUCode,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        Jump,
  output logic        JALR,
  output logic        SB_type
`ifdef RV32I_DECODE_ILLEGAL_EN
  ,
  output logic        illegal
`endif
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  ctrl_t       ctrl_d, ctrl_q;
  logic [31:0] imm_d, imm_q, off_d, off_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [2:0]  f3_q;
  logic        kill;

  assign opcode = Instruction[6:0];
  assign f3     = Instruction[14:12];

  rv32i_imm_gen u_imm_gen (
    .instr_i (Instruction[31:7]),
    .imm_i_o (imm_i),
    .imm_s_o (imm_s),
    .imm_b_o (imm_b),
    .imm_u_o (imm_u),
    .imm_j_o (imm_j)
  );

  // Per-opcode control, immediate and offset selection
  always_comb begin
    ctrl_d = '0;
    imm_d  = '0;
    off_d  = '0;
    case (opcode)
      OP_R: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src_b = SRCB_RS2;
        ctrl_d.alu_code  = alu_op(f3, Instruction[30]);
      end
      OP_I: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        // bit 30 is part of the immediate except for SRAI
        ctrl_d.alu_code  = alu_op(f3, Instruction[30] && (f3 == 3'b101));
        imm_d = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, Instruction[24:20]} : imm_i;
      end
      OP_LOAD: begin
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src_b  = SRCB_IMM;
        ctrl_d.alu_code   = ALU_ADD;
        imm_d = imm_i;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_code  = ALU_ADD;
        imm_d = imm_s;
      end
      OP_BRANCH: begin
        ctrl_d.sb_type   = 1'b1;
        ctrl_d.alu_src_b = SRCB_RS2;
        ctrl_d.alu_code  = ALU_ADD;
        off_d = imm_b;
      end
      OP_LUI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_code  = ALU_LUI;
        imm_d = imm_u;
      end
      OP_AUIPC: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_code  = ALU_ADD;
        imm_d = imm_u;
      end
      OP_JAL: begin
        ctrl_d.jump      = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
        ctrl_d.alu_code  = ALU_ADD;
        off_d = imm_j;
      end
      OP_JALR: begin
        ctrl_d.jalr      = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
        ctrl_d.alu_code  = ALU_ADD;
        off_d = imm_i;
      end
      default: ;
    endcase
  end

`ifdef RV32I_DECODE_ILLEGAL_EN
  logic       illegal_d, illegal_q;
  logic [6:0] funct7;
  assign funct7 = Instruction[31:25];

  // Unsupported opcodes and funct3/funct7 pairs RV32I leaves undefined
  always_comb begin
    illegal_d = 1'b0;
    case (opcode)
      OP_R:
        illegal_d = !((funct7 == 7'b0000000) ||
                      (funct7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      OP_I:
        if (f3 == 3'b001)      illegal_d = (funct7 != 7'b0000000);
        else if (f3 == 3'b101) illegal_d = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
        else                   illegal_d = 1'b0;
      OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR:
        illegal_d = 1'b0;
      default:
        illegal_d = 1'b1;
    endcase
  end

  // Illegal flag register
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
  assign kill    = illegal_d;
`else
  assign kill    = 1'b0;
`endif

  // ID/EX register: reset wins, then a killed decode loads a NOP
  always_ff @(posedge clk) begin
    if (reset || kill) begin
      ctrl_q <= '0;
      imm_q  <= '0;
      off_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      f3_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      imm_q  <= imm_d;
      off_q  <= off_d;
      rs1_q  <= Instruction[19:15];
      rs2_q  <= Instruction[24:20];
      rd_q   <= Instruction[11:7];
      f3_q   <= f3;
    end
  end

  assign rs1Addr  = rs1_q;
  assign rs2Addr  = rs2_q;
  assign rdAddr   = rd_q;
  assign funct3   = f3_q;
  assign Imm      = imm_q;
  assign offset   = off_q;
  assign ALUCode  = ctrl_q.alu_code;
  assign ALUSrcA  = ctrl_q.alu_src_a;
  assign ALUSrcB  = ctrl_q.alu_src_b;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign Jump     = ctrl_q.jump;
  assign JALR     = ctrl_q.jalr;
  assign SB_type  = ctrl_q.sb_type;

endmodule

// File: tb/tb_rv32i_decode.sv
// Scoreboard bench for rv32i_decode: directed instructions with hand-decoded
// expectations queued at issue, checked by an independent monitor one edge later.
module tb_rv32i_decode;

  logic        clk;
  logic        reset;
  logic [31:0] Instruction;
  logic [4:0]  rs1Addr, rs2Addr, rdAddr;
  logic [2:0]  funct3;
  logic [31:0] Imm, offset;
  logic [3:0]  ALUCode;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        MemRead, MemWrite, MemtoReg, RegWrite, Jump, JALR, SB_type;

  typedef struct {
    string       name;
    logic [95:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rv32i_decode dut (
    .clk         (clk),
    .reset       (reset),
    .Instruction (Instruction),
    .rs1Addr     (rs1Addr),
    .rs2Addr     (rs2Addr),
    .rdAddr      (rdAddr),
    .funct3      (funct3),
    .Imm         (Imm),
    .offset      (offset),
    .ALUCode     (ALUCode),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .Jump        (Jump),
    .JALR        (JALR),
    .SB_type     (SB_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {MemRead, MemWrite, MemtoReg, RegWrite, Jump, JALR, SB_type}
  function automatic logic [95:0] ev(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic [2:0] f3,
                                     input logic [31:0] imm, input logic [31:0] off,
                                     input logic [3:0] alu, input logic sa,
                                     input logic [1:0] sbsel, input logic [6:0] ctl);
    return {rs1, rs2, rd, f3, imm, off, alu, sa, sbsel, ctl};
  endfunction

  task automatic issue(input string nm, input logic r, input logic [31:0] ins,
                       input logic [95:0] v);
    exp_t e;
    @(negedge clk);
    reset       = r;
    Instruction = ins;
    e.name = nm;
    e.v    = v;
    sb.push_back(e);
  endtask

  // Monitor: every output sample after an edge consumes one expectation
  initial begin
    exp_t        e;
    logic [95:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {rs1Addr, rs2Addr, rdAddr, funct3, Imm, offset, ALUCode, ALUSrcA,
               ALUSrcB, MemRead, MemWrite, MemtoReg, RegWrite, Jump, JALR, SB_type};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.v);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    Instruction = 32'h0;

    issue("reset_state", 1'b1, 32'h00003f37, '0);
    issue("lui",         1'b0, 32'h00003f37,
          ev(5'd0, 5'd0, 5'd30, 3'd3, 32'h00003000, 32'h0, 4'd2, 1'b0, 2'b01, 7'h08));
    issue("reset_prio",  1'b1, 32'h00003f37, '0);
    issue("jalr",        1'b0, 32'h02000fe7,
          ev(5'd0, 5'd0, 5'd31, 3'd0, 32'h0, 32'h00000020, 4'd0, 1'b1, 2'b10, 7'h0a));
    issue("bne",         1'b0, 32'h00001c63,
          ev(5'd0, 5'd0, 5'd24, 3'd1, 32'h0, 32'h00000018, 4'd0, 1'b0, 2'b00, 7'h01));
    issue("beq_neg",     1'b0, 32'hfc000ae3,
          ev(5'd0, 5'd0, 5'd21, 3'd0, 32'h0, 32'hffffffd4, 4'd0, 1'b0, 2'b00, 7'h01));
    issue("sub",         1'b0, 32'h406283b3,
          ev(5'd5, 5'd6, 5'd7, 3'd0, 32'h0, 32'h0, 4'd1, 1'b0, 2'b00, 7'h08));
    issue("sltu",        1'b0, 32'h00733e33,
          ev(5'd6, 5'd7, 5'd28, 3'd3, 32'h0, 32'h0, 4'd10, 1'b0, 2'b00, 7'h08));
    issue("sw",          1'b0, 32'h001c2623,
          ev(5'd24, 5'd1, 5'd12, 3'd2, 32'h0000000c, 32'h0, 4'd0, 1'b0, 2'b01, 7'h20));
    issue("lw",          1'b0, 32'h00432e83,
          ev(5'd6, 5'd4, 5'd29, 3'd2, 32'h00000004, 32'h0, 4'd0, 1'b0, 2'b01, 7'h58));
    issue("slli",        1'b0, 32'h002e9293,
          ev(5'd29, 5'd2, 5'd5, 3'd1, 32'h00000002, 32'h0, 4'd6, 1'b0, 2'b01, 7'h08));
    issue("jal",         1'b0, 32'h00000f6f,
          ev(5'd0, 5'd0, 5'd30, 3'd0, 32'h0, 32'h0, 4'd0, 1'b1, 2'b10, 7'h0c));
    issue("srai_shamt",  1'b0, 32'h4030d213,
          ev(5'd1, 5'd3, 5'd4, 3'd5, 32'h00000003, 32'h0, 4'd8, 1'b0, 2'b01, 7'h08));
    issue("addi_neg",    1'b0, 32'hfff00093,
          ev(5'd0, 5'd31, 5'd1, 3'd0, 32'hffffffff, 32'h0, 4'd0, 1'b0, 2'b01, 7'h08));
    issue("auipc",       1'b0, 32'hfffff097,
          ev(5'd31, 5'd31, 5'd1, 3'd7, 32'hfffff000, 32'h0, 4'd0, 1'b1, 2'b01, 7'h08));
    issue("unsupported", 1'b0, 32'h12345677,
          ev(5'd8, 5'd3, 5'd12, 3'd5, 32'h0, 32'h0, 4'd0, 1'b0, 2'b00, 7'h00));

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
